// File: rtl/gera_janela_3x3.sv
// gera_janela_3x3: streaming 3x3 window generator with two line buffers, feeding the 9-input median sorter
module gera_janela_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       limpa,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          w1,
    output logic [DATA_W-1:0]          w2,
    output logic [DATA_W-1:0]          w3,
    output logic [DATA_W-1:0]          w4,
    output logic [DATA_W-1:0]          w5,
    output logic [DATA_W-1:0]          w6,
    output logic [DATA_W-1:0]          w7,
    output logic [DATA_W-1:0]          w8,
    output logic [DATA_W-1:0]          w9,
    output logic [$clog2(IMG_H)-1:0]   out_lin,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       frame_done
);
    localparam int LW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0]               col_q, col_d;
    logic [LW-1:0]               lin_q, lin_d;
    logic [DATA_W-1:0]           lb0_q [IMG_W];
    logic [DATA_W-1:0]           lb1_q [IMG_W];
    // Column registers hold {row r-2, row r-1, row r}; ca = two columns back, cb = previous column
    logic [2:0][DATA_W-1:0]      ca_q, ca_d, cb_q, cb_d, new_col;
    logic [8:0][DATA_W-1:0]      win_q, win_d;
    logic [LW-1:0]               out_lin_q, out_lin_d;
    logic [CW-1:0]               out_col_q, out_col_d;
    logic                        out_valid_q, out_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        acc, emit, last_col, last_lin;

    assign in_ready   = ~out_valid_q | out_ready;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_lin    = out_lin_q;
    assign out_col    = out_col_q;
    assign {w1, w2, w3, w4, w5, w6, w7, w8, w9} = win_q;

    // Accept/emit decisions, raster counters, window shift and output staging
    always_comb begin
        acc          = in_valid & in_ready & ~limpa;
        last_col     = col_q == CW'(IMG_W - 1);
        last_lin     = lin_q == LW'(IMG_H - 1);
        emit         = acc && lin_q >= LW'(2) && col_q >= CW'(2);
        new_col      = {lb1_q[col_q], lb0_q[col_q], in_pixel};
        col_d        = limpa ? '0 : acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
        lin_d        = limpa ? '0 : (acc && last_col) ? (last_lin ? '0 : lin_q + 1'b1) : lin_q;
        ca_d         = acc ? cb_q : ca_q;
        cb_d         = acc ? new_col : cb_q;
        win_d        = emit ? {ca_q[2], cb_q[2], new_col[2],
                               ca_q[1], cb_q[1], new_col[1],
                               ca_q[0], cb_q[0], new_col[0]} : win_q;
        out_lin_d    = emit ? lin_q - 1'b1 : out_lin_q;
        out_col_d    = emit ? col_q - 1'b1 : out_col_q;
        out_valid_d  = limpa ? 1'b0 : emit ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        frame_done_d = acc & last_col & last_lin;
    end

    // Line buffers: no reset, stale rows are never used because rows 0/1 emit nothing
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_pixel;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            lin_q        <= '0;
            ca_q         <= '0;
            cb_q         <= '0;
            win_q        <= '0;
            out_lin_q    <= '0;
            out_col_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            lin_q        <= lin_d;
            ca_q         <= ca_d;
            cb_q         <= cb_d;
            win_q        <= win_d;
            out_lin_q    <= out_lin_d;
            out_col_q    <= out_col_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
